regport_ctrl: RTL and testbench

Register-port controller sitting between the datapath and the 18-entry register bank (R0–R15, SP = 16, PC = 17). It drives the bank's single write port and two combinational read ports. It accepts up to two writebacks per cycle (e.g. ALU result plus SP update) into a small ordered queue and drains them one per cycle. Read requests are answered one cycle later, with data forwarded from writes still in the queue.

---
 rtl/regport_pkg.sv | 13 +
 rtl/regport_wbq.sv | 85 ++++++++
 rtl/regport_ctrl.sv | 110 +++++++++++
 tb/tb_regport_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regport_pkg.sv
// rtl/regport_pkg.sv - shared widths, register indices and write-queue entry type
package regport_pkg;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 18;
  localparam int SP_IDX   = 16;
  localparam int PC_IDX   = 17;

  typedef struct packed {
    logic [IDX_W-1:0]  dr;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/regport_wbq.sv
// rtl/regport_wbq.sv - ordered write queue with two youngest-match lookup ports
// REGPORT_FWD_EN adds the lookup data outputs used for read forwarding.
module regport_wbq
  import regport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0,
  input  wbq_entry_t             push0_entry,
  input  logic                   push1,
  input  wbq_entry_t             push1_entry,
  input  logic                   pop,
  output wbq_entry_t             head_entry,
  output logic [$clog2(DEPTH):0] count,
  input  logic [IDX_W-1:0]       lk_idx1,
  input  logic [IDX_W-1:0]       lk_idx2,
  output logic                   lk_hit1,
`ifdef REGPORT_FWD_EN
  output logic [DATA_W-1:0]      lk_data1,
  output logic [DATA_W-1:0]      lk_data2,
`endif
  output logic                   lk_hit2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail1;
  logic [PW-1:0] slot;
  logic          pop_en;

  assign pop_en     = pop & (count != '0);
  // wb1 lands behind wb0 only when wb0 is actually enqueued
  assign tail1      = tail + PW'(push0);
  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (push0) mem[tail]  <= push0_entry;
    if (push1) mem[tail1] <= push1_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_en);
      tail  <= tail + PW'(push0) + PW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop_en);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lk_hit1 = 1'b0;
    lk_hit2 = 1'b0;
`ifdef REGPORT_FWD_EN
    lk_data1 = '0;
    lk_data2 = '0;
`endif
    slot = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < count) begin
        if (mem[slot].dr == lk_idx1) begin
          lk_hit1 = 1'b1;
`ifdef REGPORT_FWD_EN
          lk_data1 = mem[slot].data;
`endif
        end
        if (mem[slot].dr == lk_idx2) begin
          lk_hit2 = 1'b1;
`ifdef REGPORT_FWD_EN
          lk_data2 = mem[slot].data;
`endif
        end
      end
    end
  end
endmodule

// File: rtl/regport_ctrl.sv
// rtl/regport_ctrl.sv - register-bank port controller: writeback queue, drain, checked reads
// REGPORT_FWD_EN selects read forwarding from the queue; otherwise reads stall on queued matches.
module regport_ctrl
  import regport_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = regport_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [IDX_W-1:0]  rd_sr1,
  input  logic [IDX_W-1:0]  rd_sr2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  input  logic              wb0_valid,
  input  logic              wb1_valid,
  input  logic [IDX_W-1:0]  wb0_dr,
  input  logic [IDX_W-1:0]  wb1_dr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb_ready,
  output logic [IDX_W-1:0]  rb_sr1,
  output logic [IDX_W-1:0]  rb_sr2,
  input  logic [DATA_W-1:0] rb_rdata1,
  input  logic [DATA_W-1:0] rb_rdata2,
  output logic [IDX_W-1:0]  rb_dr,
  output logic [DATA_W-1:0] rb_wrdata,
  output logic              rb_write,
  output logic              q_empty,
  output logic              idx_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(NUM_REGS);

  wbq_entry_t        head_entry;
  logic [CW-1:0]     count;
  logic              hit1, hit2;
  logic [DATA_W-1:0] op1, op2;
  logic              wb0_ok, wb1_ok, sr1_ok, sr2_ok;
  logic              push0, push1, rd_acc, wb_bad;

  assign wb0_ok = {1'b0, wb0_dr} < IDX_LIM;
  assign wb1_ok = {1'b0, wb1_dr} < IDX_LIM;
  assign sr1_ok = {1'b0, rd_sr1} < IDX_LIM;
  assign sr2_ok = {1'b0, rd_sr2} < IDX_LIM;

  // Pairs are accepted whole, so readiness only looks at free space.
  assign wb_ready = !reset && ((CW'(DEPTH) - count) >= CW'(2));
  assign push0    = wb0_valid & wb_ready & wb0_ok;
  assign push1    = wb1_valid & wb_ready & wb1_ok;
  assign wb_bad   = wb_ready & ((wb0_valid & !wb0_ok) | (wb1_valid & !wb1_ok));

  assign q_empty   = (count == '0);
  assign rb_write  = !q_empty && !reset;
  assign rb_dr     = head_entry.dr;
  assign rb_wrdata = head_entry.data;
  assign rb_sr1    = rd_sr1;
  assign rb_sr2    = rd_sr2;

`ifdef REGPORT_FWD_EN
  logic [DATA_W-1:0] fwd1, fwd2;
  assign rd_ready = !reset;
  assign op1      = hit1 ? fwd1 : rb_rdata1;
  assign op2      = hit2 ? fwd2 : rb_rdata2;
`else
  assign rd_ready = !reset && !hit1 && !hit2;
  assign op1      = rb_rdata1;
  assign op2      = rb_rdata2;
`endif
  assign rd_acc = rd_valid & rd_ready;

  regport_wbq #(.DEPTH(DEPTH)) u_wbq (
    .clk         (clk),
    .reset       (reset),
    .push0       (push0),
    .push0_entry ('{dr: wb0_dr, data: wb0_data}),
    .push1       (push1),
    .push1_entry ('{dr: wb1_dr, data: wb1_data}),
    .pop         (rb_write),
    .head_entry  (head_entry),
    .count       (count),
    .lk_idx1     (rd_sr1),
    .lk_idx2     (rd_sr2),
    .lk_hit1     (hit1),
`ifdef REGPORT_FWD_EN
    .lk_data1    (fwd1),
    .lk_data2    (fwd2),
`endif
    .lk_hit2     (hit2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      idx_err   <= 1'b0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_data1 <= sr1_ok ? op1 : '0;
        rsp_data2 <= sr2_ok ? op2 : '0;
      end
      if ((rd_acc && (!sr1_ok || !sr2_ok)) || wb_bad) idx_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regport_ctrl.sv
// tb/tb_regport_ctrl.sv - randomized bench for regport_ctrl against an architectural register model
module tb_regport_ctrl;
  import regport_pkg::*;
  localparam int DEPTH = 4;
  localparam int NR    = 18;
`ifdef REGPORT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_valid, rd_ready, rsp_valid, wb0_valid, wb1_valid, wb_ready, rb_write, q_empty, idx_err;
  logic [4:0] rd_sr1, rd_sr2, wb0_dr, wb1_dr, rb_sr1, rb_sr2, rb_dr;
  logic [31:0] rsp_data1, rsp_data2, wb0_data, wb1_data, rb_rdata1, rb_rdata2, rb_wrdata;

  regport_ctrl #(.DEPTH(DEPTH), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_sr1(rd_sr1), .rd_sr2(rd_sr2), .rsp_valid(rsp_valid),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb0_dr(wb0_dr), .wb1_dr(wb1_dr),
    .wb0_data(wb0_data), .wb1_data(wb1_data), .wb_ready(wb_ready),
    .rb_sr1(rb_sr1), .rb_sr2(rb_sr2), .rb_rdata1(rb_rdata1), .rb_rdata2(rb_rdata2),
    .rb_dr(rb_dr), .rb_wrdata(rb_wrdata), .rb_write(rb_write),
    .q_empty(q_empty), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  // Register bank: combinational reads, one write port.
  logic [31:0] bank [32];
  logic [31:0] init_val [32];
  bit preload = 1'b1;
  assign rb_rdata1 = bank[rb_sr1];
  assign rb_rdata2 = bank[rb_sr2];
  always @(posedge clk) begin
    if (preload) bank <= init_val;
    else if (rb_write) bank[rb_dr] <= rb_wrdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arch = value a read must see, committed = value the bank holds.
  logic [31:0] arch [32];
  logic [31:0] committed [32];
  int          mq_dr [$];
  logic [31:0] mq_data [$];
  bit          m_rsp = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_d1, m_d2;

  always @(negedge clk) begin : cmp
    int sz;
    bit exp_rdy, exp_wbr;
    if (reset) begin
      chk("rb_write_in_reset", rb_write, 0);
      mq_dr.delete();
      mq_data.delete();
      arch  = committed;
      m_rsp = 1'b0;
      m_err = 1'b0;
    end else begin
      sz      = mq_dr.size();
      exp_wbr = (DEPTH - sz) >= 2;
      exp_rdy = 1'b1;
      if (!FWD)
        foreach (mq_dr[i]) if (mq_dr[i] == int'(rd_sr1) || mq_dr[i] == int'(rd_sr2)) exp_rdy = 1'b0;
      chk("q_empty", q_empty, sz == 0);
      chk("rb_write", rb_write, sz != 0);
      if (sz != 0 && rb_write === 1'b1) begin
        chk("rb_dr", rb_dr, mq_dr[0]);
        chk("rb_wrdata", rb_wrdata, mq_data[0]);
      end
      chk("wb_ready", wb_ready, exp_wbr);
      if (rd_valid) chk("rd_ready", rd_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_rsp);
      if (m_rsp) begin
        chk("rsp_data1", rsp_data1, m_d1);
        chk("rsp_data2", rsp_data2, m_d2);
      end
      chk("idx_err", idx_err, m_err);
      // advance to the next edge: read sees state before this edge's writes
      m_rsp = rd_valid && exp_rdy;
      if (m_rsp) begin
        m_d1 = (rd_sr1 < NR) ? arch[rd_sr1] : 32'd0;
        m_d2 = (rd_sr2 < NR) ? arch[rd_sr2] : 32'd0;
        if (rd_sr1 >= NR || rd_sr2 >= NR) m_err = 1'b1;
      end
      if (sz != 0) begin
        committed[mq_dr[0]] = mq_data[0];
        void'(mq_dr.pop_front());
        void'(mq_data.pop_front());
      end
      if (exp_wbr) begin
        if (wb0_valid) begin
          if (wb0_dr < NR) begin
            mq_dr.push_back(int'(wb0_dr)); mq_data.push_back(wb0_data); arch[wb0_dr] = wb0_data;
          end else m_err = 1'b1;
        end
        if (wb1_valid) begin
          if (wb1_dr < NR) begin
            mq_dr.push_back(int'(wb1_dr)); mq_data.push_back(wb1_data); arch[wb1_dr] = wb1_data;
          end else m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = 0; wb0_valid = 0; wb1_valid = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q_empty !== 1'b1 && n < 20) begin tick(); n++; end
    chk("drain_timeout", q_empty, 1);
  endtask

  task automatic read_wait(input logic [4:0] s1, input logic [4:0] s2, output int stalls);
    rd_valid = 1; rd_sr1 = s1; rd_sr2 = s2; stalls = 0;
    #1;
    while (rd_ready !== 1'b1 && stalls < 20) begin tick(); stalls++; end
    chk("read_timeout", rd_ready, 1);
    tick();
    rd_valid = 0;
  endtask

  function automatic logic [4:0] ridx();
    int r = $urandom_range(0, 15);
    if (r == 0) return 5'($urandom_range(18, 31));
    if (r < 8) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 17));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bit acc;
    int sent;
    idle();
    rd_sr1 = 0; rd_sr2 = 0; wb0_dr = 0; wb1_dr = 0; wb0_data = 0; wb1_data = 0;
    for (int i = 0; i < 32; i++) init_val[i] = $urandom;
    init_val[1] = 32'h1111;
    init_val[3] = 32'd150000;
    init_val[4] = 32'd200000;
    committed = init_val;
    arch      = init_val;
    repeat (3) tick();
    reset = 0; preload = 0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data1", rsp_data1, 0);
    chk("rst_q_empty", q_empty, 1);
    chk("rst_rb_write", rb_write, 0);
    chk("rst_idx_err", idx_err, 0);

    // plain bank read
    rd_valid = 1; rd_sr1 = 3; rd_sr2 = 4;
    tick(); idle();
    chk("r3r4_valid", rsp_valid, 1);
    chk("r3_data", rsp_data1, 32'd150000);
    chk("r4_data", rsp_data2, 32'd200000);
    chk("r3r4_err", idx_err, 0);
    tick();
    chk("rsp_one_cycle", rsp_valid, 0);

    // same-register pair, youngest wins
    wb0_valid = 1; wb0_dr = 5; wb0_data = 32'h11;
    wb1_valid = 1; wb1_dr = 5; wb1_data = 32'h22;
    tick(); idle();
    read_wait(5, 0, st);
    chk("r5_pair_data", rsp_data1, 32'h22);
    chk("r5_stalls", st, FWD ? 0 : 2);

    // fill and drain with wrap
    wait_empty();
    sent = 0;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      wb0_valid = 1; wb0_dr = 6; wb0_data = 32'h100 + 32'(sent * 2);
      wb1_valid = 1; wb1_dr = 7; wb1_data = 32'h101 + 32'(sent * 2);
      #1 acc = wb_ready;
      if (c == 2) chk("fill_ready_low", acc, 0);
      tick();
      if (acc) sent++;
    end
    idle();
    chk("fill_sent", sent, 6);
    wait_empty();

    // out-of-range indices
    wb0_valid = 1; wb0_dr = 20; wb0_data = 32'hDEAD;
    rd_valid = 1; rd_sr1 = 2; rd_sr2 = 31;
    tick(); idle();
    chk("bad_rd_data2", rsp_data2, 0);
    chk("bad_idx_err", idx_err, 1);
    chk("bad_not_queued", q_empty, 1);
    repeat (3) tick();
    chk("idx_err_sticky", idx_err, 1);

    // read in the same cycle as a write to it
    rd_valid = 1; rd_sr1 = 1; rd_sr2 = 0;
    wb0_valid = 1; wb0_dr = 1; wb0_data = 32'h5;
    tick(); idle();
    chk("same_cycle_old", rsp_data1, 32'h1111);
    read_wait(1, 0, st);
    chk("next_read_new", rsp_data1, 32'h5);

    // reset discards queued writes
    wait_empty();
    wb0_valid = 1; wb0_dr = 10; wb0_data = 32'hA1;
    wb1_valid = 1; wb1_dr = 11; wb1_data = 32'hA2;
    tick();
    wb0_dr = 12; wb0_data = 32'hA3;
    wb1_dr = 13; wb1_data = 32'hA4;
    tick(); idle();
    reset = 1;
    tick();
    reset = 0;
    chk("rstq_rb_write", rb_write, 0);
    chk("rstq_q_empty", q_empty, 1);
    chk("rstq_idx_err", idx_err, 0);
    repeat (3) tick();
    chk("rstq_r10_kept", bank[10], 32'hA1);
    chk("rstq_r11_dropped", bank[11], init_val[11]);
    chk("rstq_r13_dropped", bank[13], init_val[13]);

    // random traffic
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!(wb0_valid || wb1_valid) || acc) begin
        wb0_valid = ($urandom_range(0, 2) != 0); wb0_dr = ridx(); wb0_data = $urandom;
        wb1_valid = ($urandom_range(0, 2) == 0); wb1_dr = ridx(); wb1_data = $urandom;
      end
      rd_valid = $urandom_range(0, 1); rd_sr1 = ridx(); rd_sr2 = ridx();
      #1 acc = wb_ready;
      tick();
    end
    reset = 0;
    idle();
    tick();
    wait_empty();
    tick();
    for (int i = 0; i < NR; i++) chk("final_bank", bank[i], committed[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
